// File: rtl/div_scheduler.sv
// div_scheduler
//
// Purpose:
//   Time-shares one sequential restoring divider between four requesters.
//   A round-robin arbiter picks one pending request while the unit is idle.
//   The unit latches that requester's operands and produces one quotient bit
//   per clock. It then returns the quotient, the remainder, a
//   divide-by-zero flag and the requester index.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req[3:0]     per-requester request, held with stable operands until grant
//   dividend_in  packed dividends, requester i at [i*WIDTH +: WIDTH]
//   divisor_in   packed divisors, same packing
//   grant[3:0]   one-hot, one cycle, marks the accepted request
//   busy         high whenever the unit is not idle
//   done         one-cycle pulse, result outputs valid in that cycle
//   done_id      requester index of the result on the outputs
//   quotient     floor(dividend / divisor), all ones on divide-by-zero
//   remainder    dividend mod divisor, the dividend on divide-by-zero
//   error        result came from a zero divisor
module div_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   dividend_in,
  input  logic [4*WIDTH-1:0]   divisor_in,
  output logic [3:0]           grant,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           done_id,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 error
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       done_id_q, done_id_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             error_q, error_d;

  // Divider working registers. They are never reset because they are
  // always reloaded on accept. The partial remainder of a restoring
  // divider stays below the divisor, so WIDTH bits hold it. The extra
  // sign bit only exists in the trial difference.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [WIDTH-1:0] sel_dvd;
  logic [WIDTH-1:0] sel_dvs;
  logic [WIDTH:0]   shift_v;
  logic [WIDTH:0]   trial;

  // Round-robin search starting at ptr. The first requesting index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = ptr_q + 2'(k);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign sel_dvd = dividend_in[win_idx*WIDTH +: WIDTH];
  assign sel_dvs = divisor_in[win_idx*WIDTH +: WIDTH];

  // One restoring step: bring in the next dividend bit and try a subtract.
  assign shift_v = {r_q, q_q[WIDTH-1]};
  assign trial   = shift_v - {1'b0, dvsr_q};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = 4'b0000;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    error_d     = error_q;
    r_d         = r_q;
    q_d         = q_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          ptr_d     = win_idx + 2'd1;
          grant_d   = 4'b0001 << win_idx;
          done_id_d = win_idx;
          dvsr_d    = sel_dvs;
          if (sel_dvs == '0) begin
            // A zero divisor skips the iteration and reports at once.
            state_d     = DONE;
            done_d      = 1'b1;
            error_d     = 1'b1;
            quotient_d  = '1;
            remainder_d = sel_dvd;
          end else begin
            state_d = CALC;
            r_d     = '0;
            q_d     = sel_dvd;
            cnt_d   = CW'(WIDTH - 1);
          end
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shift_v[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = DONE;
          done_d      = 1'b1;
          error_d     = 1'b0;
          quotient_d  = q_d;
          remainder_d = r_d;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // busy is registered from the next state. It rises with grant and
    // falls in the first idle cycle.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      grant_q     <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 2'd0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    r_q    <= r_d;
    q_q    <= q_d;
    dvsr_q <= dvsr_d;
    cnt_q  <= cnt_d;
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign error     = error_q;

endmodule

// File: tb/tb_div_scheduler.sv
module tb_div_scheduler;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] dividend_in;
  logic [4*W-1:0] divisor_in;
  logic [3:0]     grant;
  logic           busy;
  logic           done;
  logic [1:0]     done_id;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ptr_m = 0;
  int win   = 0;
  int gcyc  = 0;
  logic [W-1:0] a_lat, b_lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .dividend_in(dividend_in), .divisor_in(divisor_in),
    .grant(grant), .busy(busy), .done(done), .done_id(done_id),
    .quotient(quotient), .remainder(remainder), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference arbitration: scan from the pointer, first requester wins.
  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    dividend_in[i*W +: W] = a;
    divisor_in[i*W +: W]  = b;
  endtask

  // Called at a negedge with req already set. Returns at the grant cycle.
  task automatic wait_grant();
    int exp_w;
    exp_w = rr_pick(ptr_m, req);
    a_lat = dividend_in[exp_w*W +: W];
    b_lat = divisor_in[exp_w*W +: W];
    for (int n = 0; n < 4*W; n++) begin
      @(negedge clk);
      if (grant != 4'b0000) break;
    end
    chk("grant", grant, 32'(4'b0001 << exp_w));
    chk("busy_at_grant", busy, 1);
    win   = exp_w;
    gcyc  = cyc;
    ptr_m = (exp_w + 1) % 4;
    req[exp_w] = 1'b0;
  endtask

  // Called in the grant cycle. Returns in the first idle cycle.
  task automatic finish_div(input bit scramble);
    int n;
    if (b_lat == '0) begin
      chk("dz_done", done, 1);
      chk("dz_error", error, 1);
      chk("dz_quot", quotient, 32'hFF);
      chk("dz_rem", remainder, a_lat);
      chk("dz_id", done_id, win);
    end else begin
      chk("done_early", done, 0);
      n = 0;
      for (int k = 0; k < 3*W; k++) begin
        @(negedge clk);
        n++;
        if (scramble && k == 0) set_ops(win, ~a_lat, b_lat + 8'd1);
        if (done) break;
      end
      chk("latency", n, W);
      chk("quot", quotient, a_lat / b_lat);
      chk("rem", remainder, a_lat % b_lat);
      chk("error", error, 0);
      chk("done_id", done_id, win);
      chk("busy_done", busy, 1);
    end
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    logic [W-1:0] ba [5];
    logic [W-1:0] bb [5];
    int last;
    ba = '{8'd255, 8'd3, 8'd200, 8'd255, 8'd254};
    bb = '{8'd1, 8'd200, 8'd200, 8'd255, 8'd127};

    rst_n = 1'b0;
    req = 4'b0000;
    dividend_in = '0;
    divisor_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_err", error, 0);
    chk("rst_id", done_id, 0);
    rst_n = 1'b1;

    // Single request 100/7 on requester 0.
    @(negedge clk);
    set_ops(0, 8'd100, 8'd7);
    req = 4'b0001;
    wait_grant();
    finish_div(1'b0);

    // Divide by zero on requester 2.
    set_ops(2, 8'd55, 8'd0);
    req = 4'b0100;
    wait_grant();
    finish_div(1'b0);

    // Arithmetic boundaries on rotating lanes.
    for (int i = 0; i < 5; i++) begin
      set_ops(i % 4, ba[i], bb[i]);
      req = 4'b0001 << (i % 4);
      wait_grant();
      finish_div(1'b0);
    end

    // Fairness with all four requesting continuously.
    for (int i = 0; i < 4; i++) set_ops(i, 8'(37 * i + 11), 8'(i + 3));
    ptr_m = rr_pick(ptr_m, 4'b0000);
    req = 4'b0001;
    wait_grant();
    finish_div(1'b0);
    req = 4'b1111;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      chk("fair_order", win, (k + 1) % 4);
      if (k > 0) chk("fair_spacing", gcyc - last, W + 2);
      last = gcyc;
      finish_div(1'b0);
      req[win] = 1'b1;
    end

    // Requester 3 alone, then 0 and 3 together: 0 must win.
    req = 4'b1000;
    wait_grant();
    chk("r3_alone", win, 3);
    finish_div(1'b0);
    req = 4'b1001;
    wait_grant();
    chk("r0_first", win, 0);
    finish_div(1'b0);
    wait_grant();
    chk("r3_second", win, 3);
    finish_div(1'b0);

    // Operands change during the calculation.
    set_ops(1, 8'd201, 8'd13);
    req = 4'b0010;
    wait_grant();
    finish_div(1'b1);

    // Reset in the middle of a calculation.
    set_ops(0, 8'd100, 8'd7);
    req = 4'b0001;
    wait_grant();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_quot", quotient, 0);
    chk("mid_rst_rem", remainder, 0);
    chk("mid_rst_err", error, 0);
    ptr_m = 0;
    set_ops(1, 8'd9, 8'd4);
    req = 4'b0010;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      chk("no_done_in_rst", done, 0);
    end
    rst_n = 1'b1;
    wait_grant();
    chk("post_rst_win", win, 1);
    finish_div(1'b0);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++)
        set_ops(i, 8'($urandom_range(0, 255)),
                ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
      req = 4'($urandom_range(1, 15));
      wait_grant();
      finish_div(1'b0);
    end
    req = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_scheduler.md
# div_scheduler

Shares one sequential restoring divider among four requesters. Requests are selected by a round-robin arbiter. Each granted division runs one quotient bit per clock, and the block returns quotient, remainder, divide-by-zero error and requester ID. It sits between the four operand sources (A/B, B/C, C/D, D/A pairs) and the result consumer, and replaces four parallel combinational dividers with one time-shared unit.

## Interface

- WIDTH, 8, operand, quotient and remainder width (≥ 2)
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  reset, asynchronous, active-low
- req  input  4  request per requester; held high with operands stable until the matching grant bit
- dividend_in  input  4*WIDTH  packed dividends; requester i uses bits [i*WIDTH +: WIDTH]
- divisor_in  input  4*WIDTH  packed divisors, same packing
- grant  output  4  one-hot, high for one cycle when a request is accepted
- busy  output  1  high whenever the state is not IDLE
- done  output  1  one-cycle pulse; result outputs are valid in that cycle
- done_id  output  2  index of the requester whose result is on the outputs
- quotient  output  WIDTH  floor(dividend / divisor)
- remainder  output  WIDTH  dividend mod divisor
- error  output  1  high when the result came from a zero divisor

## Operation

- States: IDLE, CALC, DONE. All outputs are registered.
- Arbitration happens in IDLE only, at a rising edge where req != 0.
  - Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins.
  - ptr is updated to winner+1 (mod 4).
  - The winner's operands are latched, grant[winner] is set for one cycle, and done_id is set to the winner.
- Zero divisor: IDLE goes directly to DONE.
  - done=1, error=1, quotient = all ones, remainder = the dividend.
- Nonzero divisor: IDLE goes to CALC.
  - Load: R (WIDTH+1 bits) = 0, Q = dividend, cnt = WIDTH-1.
- CALC iteration, one per edge:
  - t = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, divisor}.
  - If t ≥ 0 (t[WIDTH]==0): R = t, Q = {Q[WIDTH-2:0], 1}.
  - Otherwise: R = {R[WIDTH-1:0], Q[WIDTH-1]}, Q = {Q[WIDTH-2:0], 0}.
  - cnt decrements.
- On the edge where cnt==0 the final iteration completes, and:
  - the state goes to DONE;
  - quotient = Q, remainder = R[WIDTH-1:0], error = 0, done = 1.
- DONE goes to IDLE on the next edge and done clears.
- quotient, remainder, error and done_id hold their values until the next result is written.
- req is ignored outside IDLE. A requester must drop req after seeing its grant; a req still high at the next IDLE edge is treated as a new request.
- Reset:
  - Every output is 0, the state is IDLE and ptr = 0.
  - A reset asserted mid-operation discards the division immediately, and no done is produced.

## Timing

- Edge E0 accepts the request; grant is high in the cycle after E0.
- Nonzero divisor:
  - iterations occur at E1..E(WIDTH);
  - done is high in the cycle after E(WIDTH), so the latency from the grant cycle to the done cycle is WIDTH cycles;
  - the state returns to IDLE at E(WIDTH+1);
  - the next accept is possible at E(WIDTH+2).
- Zero divisor: grant and done are high in the same cycle (after E0), IDLE is reached at E1, and the next accept is possible at E2.
- Back-to-back throughput is one division per WIDTH+2 cycles. For WIDTH=8 that is one every 10 cycles.
- busy rises in the grant cycle and falls in the first IDLE cycle.

## Test plan

- Single request, WIDTH=8: req=0001, a0=100, b0=7 → grant=0001 for 1 cycle, then done 8 cycles later with quotient=14, remainder=2, done_id=0, error=0.
- Divide by zero: req=0100, a2=55, b2=0 → grant=0100 and done in the same cycle, error=1, quotient=0xFF, remainder=55, done_id=2; busy is high for 1 cycle.
- Arithmetic boundaries:
  - 255/1 → 255 r 0;
  - 3/200 → 0 r 3;
  - 200/200 → 1 r 0;
  - 255/255 → 1 r 0;
  - 254/127 → 2 r 0.
- Fairness: req=1111 held continuously, with the grant bit dropped each time → grants in order 0,1,2,3,0, one every 10 cycles, and done_id matches each grant. Then grant req3 alone, followed by req=1001 → req0 is granted before req3.
- Reset mid-operation: assert rst_n=0 at the 4th CALC cycle → grant, busy, done, quotient and the other outputs are 0 immediately, and no done follows. After release with req=0010 pending → grant=0010, since ptr restarts at 0 and requester 0 is not requesting.
- Operand stability: change dividend_in for the granted requester during CALC → the result still reflects the operands latched at E0.
